// File: rtl/switch_debounce.sv
// Switch/button debouncer: two-flop synchronisers, a whole-vector switch
// debouncer with a change strobe, and a 4-state button FSM with a press pulse.
module switch_debounce #(
  parameter int DB_CNT = 500000,
  parameter int CNT_W  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw_raw,
  input  logic        btn_raw,
  output logic [15:0] sw_stable,
  output logic        sw_changed,
  output logic        btn_level,
  output logic        btn_pulse
);

  // Terminal count: the input has been steady long enough once the counter sits here.
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_CNT - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  logic [15:0]      r_sw_s1, r_sw_s2;
  logic             r_btn_s1, r_btn_s2;
  logic [15:0]      r_cand;
  logic [CNT_W-1:0] r_sw_cnt;
  logic [CNT_W-1:0] r_btn_cnt;
  btn_state_t       r_state;
  btn_state_t       w_next;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_pulse;
  logic             w_level;

  // Two-flop synchronisers; nothing below touches the raw pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_sw_s1  <= sw_raw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= btn_raw;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Switch vector debounce: any bit change restarts the count for the whole vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand     <= '0;
      r_sw_cnt   <= '0;
      sw_stable  <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= 1'b0;
      if (r_sw_s2 != r_cand) begin
        r_cand   <= r_sw_s2;
        r_sw_cnt <= '0;
      end else if (r_sw_cnt != LP_LAST) begin
        r_sw_cnt <= r_sw_cnt + 1'b1;
      end else if (r_cand != sw_stable) begin
        sw_stable  <= r_cand;
        sw_changed <= 1'b1;
      end
    end
  end

  // Button FSM next state; a release bounce while held returns to HELD silently.
  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    w_pulse   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_btn_s2) begin
          w_next    = PRESS_WAIT;
          w_cnt_clr = 1'b1;
        end
      end
      PRESS_WAIT: begin
        if (!r_btn_s2) begin
          w_next = IDLE;
        end else if (r_btn_cnt == LP_LAST) begin
          w_next  = HELD;
          w_pulse = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      HELD: begin
        if (!r_btn_s2) begin
          w_next    = RELEASE_WAIT;
          w_cnt_clr = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (r_btn_s2) begin
          w_next = HELD;
        end else if (r_btn_cnt == LP_LAST) begin
          w_next = IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
    w_level = (w_next == HELD) || (w_next == RELEASE_WAIT);
  end

  // Button state, counter and registered outputs (level and pulse rise together).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_btn_cnt <= '0;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      r_state   <= w_next;
      btn_level <= w_level;
      btn_pulse <= w_pulse;
      if (w_cnt_clr)
        r_btn_cnt <= '0;
      else if (w_cnt_inc)
        r_btn_cnt <= r_btn_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed scenarios plus random traffic, checked
// cycle by cycle against a run-length reference model through a scoreboard.
module tb_switch_debounce;

  localparam int DB = 4;
  localparam int CW = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_raw;
  logic        btn_raw;
  logic [15:0] sw_stable;
  logic        sw_changed;
  logic        btn_level;
  logic        btn_pulse;

  always #5 clk = ~clk;

  switch_debounce #(.DB_CNT(DB), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .btn_raw    (btn_raw),
    .sw_stable  (sw_stable),
    .sw_changed (sw_changed),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse)
  );

  typedef struct packed {
    logic [15:0] st;
    logic        ch;
    logic        lv;
    logic        pl;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  // Reference model: a value is accepted once the synchronised input has shown
  // it on DB+1 consecutive clock edges and it differs from the accepted value.
  logic [15:0] m_sw_d1, m_sw_d2, m_sw_acc;
  logic        m_b_d1, m_b_d2, m_b_acc;
  logic [15:0] m_sw_hist[$];
  logic        m_b_hist[$];

  function automatic void model_edge(input logic r, input logic [15:0] s, input logic b);
    exp_t        e;
    logic [15:0] sw_seen;
    logic        b_seen;
    bit          sw_run, b_run;
    e = '0;
    if (r) begin
      m_sw_d1 = '0; m_sw_d2 = '0; m_sw_acc = '0;
      m_b_d1 = 1'b0; m_b_d2 = 1'b0; m_b_acc = 1'b0;
      m_sw_hist.delete(); m_sw_hist.push_back(16'h0000);
      m_b_hist.delete();  m_b_hist.push_back(1'b0);
    end else begin
      sw_seen = m_sw_d2; m_sw_d2 = m_sw_d1; m_sw_d1 = s;
      b_seen  = m_b_d2;  m_b_d2  = m_b_d1;  m_b_d1  = b;
      m_sw_hist.push_back(sw_seen);
      m_b_hist.push_back(b_seen);
      if (m_sw_hist.size() > DB + 1) void'(m_sw_hist.pop_front());
      if (m_b_hist.size() > DB + 1)  void'(m_b_hist.pop_front());
      sw_run = (m_sw_hist.size() == DB + 1);
      foreach (m_sw_hist[i]) if (m_sw_hist[i] != sw_seen) sw_run = 0;
      b_run = (m_b_hist.size() == DB + 1);
      foreach (m_b_hist[i]) if (m_b_hist[i] != b_seen) b_run = 0;
      if (sw_run && sw_seen != m_sw_acc) begin
        m_sw_acc = sw_seen;
        e.ch = 1'b1;
      end
      if (b_run && b_seen != m_b_acc) begin
        m_b_acc = b_seen;
        e.pl = b_seen;
      end
      e.st = m_sw_acc;
      e.lv = m_b_acc;
    end
    sb.push_back(e);
  endfunction

  // Drive one cycle of inputs ahead of the next rising edge and queue its expectation.
  task automatic step(input logic r, input logic [15:0] s, input logic b);
    @(negedge clk);
    rst = r; sw_raw = s; btn_raw = b;
    model_edge(r, s, b);
  endtask

  task automatic hold(input int n, input logic [15:0] s, input logic b);
    for (int i = 0; i < n; i++) step(1'b0, s, b);
  endtask

  // Monitor: after every rising edge, pop the expectation for that edge and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_chk++;
        if (sw_stable === e.st && sw_changed === e.ch && btn_level === e.lv && btn_pulse === e.pl)
          n_pass++;
        else
          $display("FAIL outputs cyc=%0d got st=%h ch=%b lv=%b pl=%b expected st=%h ch=%b lv=%b pl=%b",
                   cyc, sw_stable, sw_changed, btn_level, btn_pulse, e.st, e.ch, e.lv, e.pl);
      end
    end
  end

  initial begin
    int          sw_hold, b_hold;
    logic [15:0] sw_v;
    logic        b_v;
    logic        r_v;
    rst = 1'b1; sw_raw = 16'hFFFF; btn_raw = 1'b1;

    // Reset with inputs asserted, then acceptance after release.
    for (int i = 0; i < 3; i++) step(1'b1, 16'hFFFF, 1'b1);
    hold(12, 16'hFFFF, 1'b1);
    hold(12, 16'h0000, 1'b0);

    // Clean change.
    hold(12, 16'hA5C3, 1'b0);
    hold(12, 16'h0000, 1'b0);

    // Bounce on bit 0, then settle high.
    for (int i = 0; i < 12; i++) step(1'b0, ((i / 2) % 2 == 0) ? 16'h0001 : 16'h0000, 1'b0);
    hold(12, 16'h0001, 1'b0);
    hold(12, 16'h0000, 1'b0);

    // Short glitch never accepted.
    hold(3, 16'h8000, 1'b0);
    hold(12, 16'h0000, 1'b0);

    // Long press, release; then a press with a 2-cycle release glitch.
    hold(20, 16'h0000, 1'b1);
    hold(12, 16'h0000, 1'b0);
    hold(12, 16'h0000, 1'b1);
    hold(2,  16'h0000, 1'b0);
    hold(12, 16'h0000, 1'b1);
    hold(12, 16'h0000, 1'b0);

    // Simultaneous switch and button events.
    hold(12, 16'h1234, 1'b1);
    hold(12, 16'h0000, 1'b0);

    // Reset mid-debounce discards the partial count.
    hold(4, 16'h3C3C, 1'b0);
    step(1'b1, 16'h3C3C, 1'b0);
    hold(12, 16'h3C3C, 1'b0);

    // Random traffic: held values of random length, occasional single-bit bounces and resets.
    sw_v = 16'h3C3C; b_v = 1'b0; sw_hold = 0; b_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (sw_hold == 0) begin
        if ($urandom_range(0, 1) == 0) sw_v = 16'($urandom);
        else sw_v = sw_v ^ (16'h0001 << $urandom_range(0, 15));
        sw_hold = $urandom_range(1, 2 * DB + 3);
      end
      if (b_hold == 0) begin
        b_v = ~b_v;
        b_hold = $urandom_range(1, 2 * DB + 3);
      end
      r_v = ($urandom_range(0, 199) == 0);
      step(r_v, sw_v, b_v);
      sw_hold--; b_hold--;
    end
    hold(12, sw_v, b_v);

    // Drain: the monitor consumes one entry per edge.
    repeat (3) @(posedge clk);
    #3;
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have parameter DB_CNT, default 500000, meaning cycles a synchronised input must hold steady before it is accepted; legal range 2..2^CNT_W.
REQ-002 The block SHALL have parameter CNT_W, default 20, meaning width of each debounce counter.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port sw_raw  input  16  asynchronous board switch levels.
REQ-006 The block SHALL have port btn_raw  input  1  asynchronous confirm-button level, 1 = pressed.
REQ-007 The block SHALL have port sw_stable  output  16  debounced switch vector; it feeds the switch-sampling stage's 16-bit data input directly.
REQ-008 The block SHALL have port sw_changed  output  1  one-cycle pulse when sw_stable updates.
REQ-009 The block SHALL have port btn_level  output  1  debounced button level.
REQ-010 The block SHALL have port btn_pulse  output  1  one-cycle pulse per accepted press.

Function
REQ-011 sw_raw and btn_raw SHALL each pass through a two-flop synchroniser (s1, s2) before any other logic; nothing downstream reads raw inputs.
REQ-012 Switch path SHALL hold a 16-bit candidate register cand and a counter sw_cnt; when s2 != cand: cand <= s2, sw_cnt <= 0.
REQ-013 When s2 == cand and sw_cnt != DB_CNT-1, sw_cnt SHALL increment; it saturates at DB_CNT-1 and never wraps.
REQ-014 When sw_cnt == DB_CNT-1, s2 == cand and cand != sw_stable, sw_stable SHALL load cand and sw_changed SHALL be 1 for exactly that following cycle; otherwise sw_changed is 0.
REQ-015 The whole vector is debounced as one unit: any bit change in s2 restarts the count for all 16 bits.
REQ-016 Latency: counting the first rising edge that samples a new, thereafter steady raw value as edge 1, sw_stable SHALL show that value after edge DB_CNT+3 and not earlier.
REQ-017 A raw change whose s2 value lasts fewer than DB_CNT cycles SHALL never reach sw_stable.
REQ-018 Button path SHALL be a 4-state FSM with counter btn_cnt: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-019 IDLE: s2=1 -> PRESS_WAIT, btn_cnt <= 0.
REQ-020 PRESS_WAIT: s2=0 -> IDLE; else btn_cnt == DB_CNT-1 -> HELD with btn_pulse = 1 for one cycle; else btn_cnt increments.
REQ-021 HELD: s2=0 -> RELEASE_WAIT, btn_cnt <= 0.
REQ-022 RELEASE_WAIT: s2=1 -> HELD with no pulse; else btn_cnt == DB_CNT-1 -> IDLE; else btn_cnt increments.
REQ-023 btn_level SHALL be a registered 1 exactly while the state is HELD or RELEASE_WAIT; btn_pulse and btn_level rise on the same edge.
REQ-024 Holding the button indefinitely SHALL produce exactly one btn_pulse; press and release latency both equal DB_CNT+3 edges per REQ-016.
REQ-025 Switch and button paths SHALL be independent; simultaneous events in both produce their respective outputs on the same cycle without interaction.
REQ-026 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 While rst=1 at a rising edge, all synchroniser flops, cand, sw_cnt, btn_cnt, sw_stable, sw_changed, btn_level and btn_pulse SHALL clear to 0 and the FSM SHALL enter IDLE.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count; no pulse is emitted during or on exit from reset.
REQ-029 After rst falls, a steady non-zero sw_raw SHALL be accepted as a normal change from 0, with sw_changed pulsing once.

Verification (DB_CNT=4, CNT_W=3)
REQ-030 Reset: sw_raw=16'hFFFF, btn_raw=1, rst high for 3 cycles -> all outputs 0 throughout; sw_stable=16'hFFFF and btn_pulse=1 after edge 7 following release, each pulse exactly 1 cycle.
REQ-031 Clean change: sw_raw 16'h0000 -> 16'hA5C3 held -> sw_stable=16'hA5C3 after edge 7, not after edge 6; sw_changed high for that single cycle.
REQ-032 Bounce: bit0 toggles every 2 cycles for 12 cycles, then holds 1 -> sw_stable stays 16'h0000 during the bounce, becomes 16'h0001 seven edges after the last toggle; exactly one sw_changed.
REQ-033 Glitch: sw_raw=16'h8000 for 3 cycles, then 16'h0000 -> sw_stable stays 16'h0000, sw_changed never asserts.
REQ-034 Button: btn_raw high 20 cycles, then low -> one btn_pulse at edge 7; btn_level 1 from edge 7 until 7 edges after release; a 2-cycle release glitch while HELD leaves btn_level 1 and produces no second pulse.
REQ-035 Reset mid-operation: sw_raw change, rst pulsed at edge 5 -> sw_stable stays 0, no sw_changed; value accepted DB_CNT+3 edges after rst falls.
